vga_pos_arbiter: RTL and testbench

VGA_POS_ARBITER -- requirements
Module: vga_pos_arbiter

---
 rtl/vga_pos_arbiter_pkg.sv | 31 +++
 rtl/vga_pos_arbiter_rr_pick.sv | 33 +++
 rtl/vga_pos_arbiter.sv | 143 ++++++++++++++
 tb/tb_vga_pos_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pos_arbiter_pkg.sv
// Shared types and constants for the sprite-position arbiter.
package vga_pos_arbiter_pkg;

    // Arbitration handshake states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
    localparam int STEP_W       = 4;

    // Add a signed step to a position in 11-bit signed arithmetic.
    // The result is clamped to the range [0, max_pos].
    function automatic logic [9:0] clamp_step(input logic [9:0]        pos,
                                              input logic [STEP_W-1:0] step,
                                              input logic [10:0]       max_pos);
        logic signed [10:0] sum;
        sum = signed'({1'b0, pos}) + signed'({{(11-STEP_W){step[STEP_W-1]}}, step});
        if (sum[10]) begin
            return '0;
        end
        if (sum > signed'(max_pos)) begin
            return max_pos[9:0];
        end
        return sum[9:0];
    endfunction

endpackage

// File: rtl/vga_pos_arbiter_rr_pick.sv
// Round-robin priority pick. It returns the first set request at or above
// the pointer, and the search wraps modulo N.
module rr_pick
    import vga_pos_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] winner_o,
    output logic         any_o
);

    logic [W-1:0] idx;

    // Scan offsets from farthest to nearest, so that the nearest set request wins.
    // NOTE: give every combinational output a default first. Otherwise a path that
    // does not assign it infers a latch.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr_i) + i) % N);
            if (req_i[idx]) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pos_arbiter.sv
// Round-robin arbiter for sprite move requests. Each accepted move updates a
// shadow position. The shadow position is copied to the VGA position outputs
// only at frame start.
module vga_pos_arbiter
    import vga_pos_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int IMG_W     = 5,
    parameter int IMG_H     = 5,
    parameter int DEFAULT_X = 0,
    parameter int DEFAULT_Y = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_frame_start,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*STEP_W-1:0] i_req_dx,
    input  logic [N_REQ*STEP_W-1:0] i_req_dy,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [9:0]              o_x_pos,
    output logic [9:0]              o_y_pos,
    output logic                    o_dirty,
    output logic [7:0]              o_move_cnt
);

    localparam int             PTR_W = $clog2(N_REQ);
    localparam logic [10:0]    MAX_X = 11'(H_ACTIVE - IMG_W);
    localparam logic [10:0]    MAX_Y = 11'(V_ACTIVE - IMG_H);
    localparam logic [9:0]     RST_X = 10'(DEFAULT_X);
    localparam logic [9:0]     RST_Y = 10'(DEFAULT_Y);

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, winner_q, pick_idx;
    logic                  pick_any;
    logic [STEP_W-1:0]     dx_q, dy_q;
    logic [9:0]            shadow_x_q, shadow_y_q;
    logic [9:0]            x_pos_q, y_pos_q;
    logic [7:0]            move_cnt_q;
    logic                  dirty_q;
    logic                  latch_winner, capture_step, apply_move;

    rr_pick #(.N(N_REQ), .W(PTR_W)) u_rr_pick (
        .req_i    (i_req_valid),
        .ptr_i    (ptr_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    // Hold the current handshake state.
    // NOTE: sequential state uses non-blocking assignments (<=), so that every
    // register samples values from before the clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic, the one-hot grant, and the datapath strobes.
    always_comb begin
        state_d      = state_q;
        o_req_ready  = '0;
        latch_winner = 1'b0;
        capture_step = 1'b0;
        apply_move   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    latch_winner = 1'b1;
                    state_d      = ST_GRANT;
                end
            end
            ST_GRANT: begin
                o_req_ready[winner_q] = 1'b1;
                if (i_req_valid[winner_q]) begin
                    capture_step = 1'b1;
                    state_d      = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                apply_move = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the winner, capture its step, and advance the pointer and move counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            winner_q   <= '0;
            ptr_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            move_cnt_q <= '0;
        end else begin
            if (latch_winner) winner_q <= pick_idx;
            if (capture_step) begin
                dx_q <= i_req_dx[int'(winner_q)*STEP_W +: STEP_W];
                dy_q <= i_req_dy[int'(winner_q)*STEP_W +: STEP_W];
            end
            if (apply_move) begin
                ptr_q      <= PTR_W'((int'(winner_q) + 1) % N_REQ);
                move_cnt_q <= move_cnt_q + 8'd1;
            end
        end
    end

    // Shadow position: apply the clamped step in APPLY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_x_q <= RST_X;
            shadow_y_q <= RST_Y;
        end else if (apply_move) begin
            shadow_x_q <= clamp_step(shadow_x_q, dx_q, MAX_X);
            shadow_y_q <= clamp_step(shadow_y_q, dy_q, MAX_Y);
        end
    end

    // Committed position: copy the pre-edge shadow at frame start. Dirty flag: a
    // registered compare of the shadow and committed positions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_pos_q <= RST_X;
            y_pos_q <= RST_Y;
            dirty_q <= 1'b0;
        end else begin
            if (i_frame_start) begin
                x_pos_q <= shadow_x_q;
                y_pos_q <= shadow_y_q;
            end
            dirty_q <= (shadow_x_q != x_pos_q) || (shadow_y_q != y_pos_q);
        end
    end

    assign o_x_pos    = x_pos_q;
    assign o_y_pos    = y_pos_q;
    assign o_dirty    = dirty_q;
    assign o_move_cnt = move_cnt_q;

endmodule

// File: tb/tb_vga_pos_arbiter.sv
// Directed bench for vga_pos_arbiter with its default parameters.
module tb_vga_pos_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_frame_start;
    logic [3:0]  i_req_valid;
    logic [15:0] i_req_dx;
    logic [15:0] i_req_dy;
    logic [3:0]  o_req_ready;
    logic [9:0]  o_x_pos;
    logic [9:0]  o_y_pos;
    logic        o_dirty;
    logic [7:0]  o_move_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_cnt  = 8'd0;
    logic [3:0]  exp_rdy;

    vga_pos_arbiter dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_req_valid   (i_req_valid),
        .i_req_dx      (i_req_dx),
        .i_req_dy      (i_req_dy),
        .o_req_ready   (o_req_ready),
        .o_x_pos       (o_x_pos),
        .o_y_pos       (o_y_pos),
        .o_dirty       (o_dirty),
        .o_move_cnt    (o_move_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one clock. Outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // A lone requester makes one full move: IDLE -> GRANT -> APPLY -> IDLE.
    task automatic move(input int idx, input logic [3:0] dx, input logic [3:0] dy);
        i_req_valid = 4'b0001 << idx;
        i_req_dx    = '0;
        i_req_dy    = '0;
        i_req_dx[idx*4 +: 4] = dx;
        i_req_dy[idx*4 +: 4] = dy;
        tick();
        check("move_grant", o_req_ready, 4'b0001 << idx);
        tick();
        i_req_valid = '0;
        check("move_apply_rdy", o_req_ready, 0);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("move_cnt", o_move_cnt, exp_cnt);
    endtask

    // Pulse frame start, then check the committed position and the cleared dirty flag.
    task automatic commit(input logic [9:0] ex, input logic [9:0] ey);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("commit_x", o_x_pos, ex);
        check("commit_y", o_y_pos, ey);
        tick();
        check("commit_dirty", o_dirty, 0);
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_frame_start = 1'b0;
        i_req_valid   = '0;
        i_req_dx      = '0;
        i_req_dy      = '0;
        tick();
        tick();
        check("rst_x", o_x_pos, 0);
        check("rst_y", o_y_pos, 0);
        check("rst_ready", o_req_ready, 0);
        check("rst_cnt", o_move_cnt, 0);
        check("rst_dirty", o_dirty, 0);
        i_rst_n = 1'b1;

        // First move (+3, +2). Dirty rises one cycle after the shadow changes.
        move(0, 4'sd3, 4'sd2);
        check("first_x_held", o_x_pos, 0);
        tick();
        check("first_dirty", o_dirty, 1);
        commit(10'd3, 10'd2);

        // X upper clamp: walk to 634, then +5 clamps to 635.
        for (int i = 0; i < 90; i++) move(0, 4'sd7, 4'sd0);
        move(0, 4'sd1, 4'sd0);
        commit(10'd634, 10'd2);
        move(0, 4'sd5, 4'sd0);
        commit(10'd635, 10'd2);
        // X lower clamp: walk down to 2, then -8 clamps to 0.
        for (int i = 0; i < 90; i++) move(0, -4'sd7, 4'sd0);
        move(0, -4'sd3, 4'sd0);
        commit(10'd2, 10'd2);
        move(0, -4'sd8, 4'sd0);
        commit(10'd0, 10'd2);
        // Y upper clamp: walk to 474, then +7 clamps to 475.
        for (int i = 0; i < 67; i++) move(0, 4'sd0, 4'sd7);
        move(0, 4'sd0, 4'sd3);
        commit(10'd0, 10'd474);
        move(0, 4'sd0, 4'sd7);
        commit(10'd0, 10'd475);

        // APPLY coincides with frame start.
        i_req_valid = 4'b0001;
        i_req_dx    = 16'h0004;
        i_req_dy    = 16'h0000;
        tick();
        tick();
        i_req_valid   = '0;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("coinc_cnt", o_move_cnt, exp_cnt);
        check("coinc_x_old", o_x_pos, 0);
        tick();
        check("coinc_dirty", o_dirty, 1);
        commit(10'd4, 10'd475);

        // The 256th move wraps the counter back to 0.
        move(0, 4'sd0, 4'sd0);
        check("cnt_wrap", o_move_cnt, 0);

        // All four requesters held valid from reset: grant order 0,1,2,3,0.
        i_rst_n     = 1'b0;
        i_req_valid = 4'b1111;
        i_req_dx    = 16'h4321;
        i_req_dy    = 16'h0000;
        tick();
        i_rst_n = 1'b1;
        exp_cnt = 8'd0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            exp_rdy = (t % 3 == 1) ? (4'b0001 << (((t - 1) / 3) % 4)) : 4'b0000;
            check("rr_ready", o_req_ready, exp_rdy);
        end
        check("rr_cnt5", o_move_cnt, 5);
        i_req_valid = '0;
        commit(10'd11, 10'd0);

        // Requester 2 withdraws during its GRANT cycle.
        i_rst_n = 1'b0;
        tick();
        i_rst_n     = 1'b1;
        i_req_valid = 4'b1100;
        i_req_dx    = 16'h1600;
        i_req_dy    = 16'h0000;
        tick();
        check("wd_grant2", o_req_ready, 4'b0100);
        i_req_valid = 4'b1000;
        tick();
        check("wd_idle_rdy", o_req_ready, 0);
        check("wd_cnt", o_move_cnt, 0);
        i_req_valid = 4'b1100;
        tick();
        check("wd_regrant2", o_req_ready, 4'b0100);
        i_req_valid = 4'b1000;
        tick();
        tick();
        check("wd_grant3", o_req_ready, 4'b1000);
        tick();
        i_req_valid = '0;
        tick();
        exp_cnt = 8'd1;
        check("wd_cnt1", o_move_cnt, exp_cnt);
        commit(10'd1, 10'd0);

        // Reset asserted during GRANT; afterwards the lowest valid index wins.
        move(1, 4'sd2, 4'sd3);
        commit(10'd3, 10'd3);
        i_req_valid = 4'b1001;
        i_req_dx    = 16'h1001;
        tick();
        check("rg_grant3", o_req_ready, 4'b1000);
        i_rst_n = 1'b0;
        #1;
        check("rg_x", o_x_pos, 0);
        check("rg_y", o_y_pos, 0);
        check("rg_ready", o_req_ready, 0);
        check("rg_cnt", o_move_cnt, 0);
        check("rg_dirty", o_dirty, 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("rg_first_grant", o_req_ready, 4'b0001);
        i_req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
